shift_sequencer: RTL
====================

# shift_sequencer

Sequencing controller for the team's 8-bit shift/rotate unit. It accepts one shift or rotate request with a 6-bit count (0–63) over a valid/ready handshake. The unit can shift at most 7 positions per pass, so the block splits the count into passes of up to 7, feeds each pass result back as the next input, and returns the final result, carry and zero flag over a second valid/ready handshake. It sits between the ALU issue logic and a single shifter instance; it owns all of that instance's inputs.

## Interface
- CNT_W, 6, width of requested shift count (max count 2^CNT_W−1)
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_fn  in  2  0=SHL, 1=SHR, 2=ROL, 3=ROR
- req_data  in  8  operand
- req_count  in  CNT_W  total positions to shift/rotate
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer takes result
- rsp_data  out  8  final result
- rsp_carry  out  1  carry of final pass (0 for ROL/ROR)
- rsp_zero  out  1  rsp_data == 0
- sh_fn  out  2  to shifter fn
- sh_count  out  3  to shifter shiftCount
- sh_in  out  8  to shifter in
- sh_out  in  8  from shifter out
- sh_c  in  1  from shifter shiftC
- busy  out  1  high in STEP or DONE

## Operation
- States: IDLE, STEP, DONE. Registers: fn_r[1:0], acc[7:0], rem[CNT_W-1:0], carry_r.
- IDLE:
  - req_ready=1.
  - On req_valid, latch fn_r=req_fn, acc=req_data, rem=req_count and carry_r=0, then go to STEP.
- STEP:
  - chunk = min(rem, 7).
  - Drive sh_fn=fn_r, sh_in=acc, sh_count=chunk. The shifter is combinational, so its result is used in the same cycle.
  - Each cycle: acc<=sh_out, rem<=rem−chunk.
  - carry_r<=sh_c if fn_r is SHL/SHR and chunk≠0; carry_r<=0 for ROL/ROR.
  - If rem−chunk==0, go to DONE; otherwise stay in STEP.
- Count 0: exactly one STEP pass with sh_count=0. Result = req_data, carry 0.
- DONE:
  - rsp_valid=1; rsp_data=acc, rsp_carry=carry_r, rsp_zero=(acc==0).
  - Outputs are held stable while rsp_ready=0.
  - On rsp_ready, go to IDLE.
- Outside STEP, sh_fn/sh_count/sh_in are driven 0.
- req_ready=0 in STEP and DONE. No request queuing; one operation is in flight at a time.
- A request offered while busy is ignored; the requester keeps req_valid high until it sees req_ready.

## Timing
- Passes P = max(1, ceil(count/7)).
- Accept edge → P STEP cycles → rsp_valid high on the cycle after the last STEP.
- Minimum request-to-response is 2 cycles: accept edge plus 1 STEP.
- Back-to-back: DONE→IDLE takes one cycle, so the next request is accepted at most every P+2 cycles.
- Reset values: state=IDLE, acc=0, rem=0, carry_r=0; req_ready=1, rsp_valid=0, rsp_data=0, rsp_carry=0, rsp_zero=1, busy=0, sh_* = 0.
- Reset mid-operation, in STEP or DONE: return to IDLE immediately. The in-flight result is discarded and no rsp_valid follows.
- rsp_valid and rsp_ready both high in DONE: the transfer completes; IDLE and req_ready follow on the next cycle.

## Test plan
The bench instantiates the team's shifter wired to the sh_* ports.
- SHL, data 0x81, count 1 → 1 pass (sh_count=1); rsp_data 0x02, carry 1, zero 0; rsp_valid 2 cycles after accept.
- ROL, data 0x81, count 9 → passes of sh_count 7 then 2; rsp_data 0x03, carry 0; rsp_valid 3 cycles after accept.
- SHR, data 0xFF, count 20 → passes 7, 7, 6; rsp_data 0x00, zero 1, carry 0. Check req_ready=0 throughout.
- Count 0, ROR, data 0x5A → 1 pass with sh_count 0; rsp_data 0x5A, carry 0. Then SHL, data 0x00, count 0 → rsp_data 0x00, zero 1.
- Backpressure: SHL 0x40 count 2 with rsp_ready low for 3 cycles → rsp_valid, rsp_data 0x00 and carry 1 held steady. A second req_valid is not accepted until the cycle after rsp_ready.
- Reset asserted during the 2nd STEP of ROL 0x01 count 14 → all outputs return to reset values at once and no response is produced. Then SHL 0x01 count 7 completes normally: 0x80, carry 0.

Source files
------------

// File: rtl/shift_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : shift_sequencer
// Purpose  : Splits a 0-63 position shift/rotate into passes of up to 7
//            through an external combinational 8-bit shifter.
// Revision : 1.0
// ============================================================================
module shift_sequencer #(
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [1:0]       req_fn,
   input  logic [7:0]       req_data,
   input  logic [CNT_W-1:0] req_count,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [7:0]       rsp_data,
   output logic             rsp_carry,
   output logic             rsp_zero,
   output logic [1:0]       sh_fn,
   output logic [2:0]       sh_count,
   output logic [7:0]       sh_in,
   input  logic [7:0]       sh_out,
   input  logic             sh_c,
   output logic             busy
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_STEP = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] C_MAX_CHUNK = CNT_W'(7);

   state_t           state_q, state_d;
   logic [1:0]       fn_q, fn_d;
   logic [7:0]       acc_q, acc_d;
   logic [CNT_W-1:0] rem_q, rem_d;
   logic             carry_q, carry_d;

   logic [2:0]       chunk;
   logic [CNT_W-1:0] rem_next;
   logic             is_shift;

   assign chunk    = (rem_q > C_MAX_CHUNK) ? 3'd7 : rem_q[2:0];
   assign rem_next = rem_q - CNT_W'(chunk);
   assign is_shift = ~fn_q[1];

   always_comb begin
      state_d = state_q;
      fn_d    = fn_q;
      acc_d   = acc_q;
      rem_d   = rem_q;
      carry_d = carry_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               fn_d    = req_fn;
               acc_d   = req_data;
               rem_d   = req_count;
               carry_d = 1'b0;
               state_d = S_STEP;
            end
         end
         S_STEP: begin
            acc_d = sh_out;
            rem_d = rem_next;
            // A zero-length pass (count 0) leaves the cleared carry untouched.
            if (!is_shift)
               carry_d = 1'b0;
            else if (chunk != 3'd0)
               carry_d = sh_c;
            if (rem_next == '0)
               state_d = S_DONE;
         end
         S_DONE: begin
            if (rsp_ready)
               state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         fn_q    <= 2'd0;
         acc_q   <= 8'd0;
         rem_q   <= '0;
         carry_q <= 1'b0;
      end else begin
         state_q <= state_d;
         fn_q    <= fn_d;
         acc_q   <= acc_d;
         rem_q   <= rem_d;
         carry_q <= carry_d;
      end
   end

   // All outputs are pure decodes of registered state.
   assign req_ready = (state_q == S_IDLE);
   assign rsp_valid = (state_q == S_DONE);
   assign busy      = (state_q == S_STEP) || (state_q == S_DONE);
   assign rsp_data  = rsp_valid ? acc_q : 8'd0;
   assign rsp_carry = rsp_valid & carry_q;
   assign rsp_zero  = (rsp_data == 8'd0);

   assign sh_fn    = (state_q == S_STEP) ? fn_q  : 2'd0;
   assign sh_count = (state_q == S_STEP) ? chunk : 3'd0;
   assign sh_in    = (state_q == S_STEP) ? acc_q : 8'd0;

endmodule
`default_nettype wire
